updown_step_scheduler: RTL

Shared up/down counter with a two-requester round-robin scheduler. Each requester asks for the counter to be stepped N times up or down. The block grants one request at a time, then runs the counter one step per clock with wrap-around (15→0 up, 0→15 down). It reports completion with a one-cycle done pulse tagged with the requester ID. It sits between control logic that needs a shared modulo position or index and the counter datapath.

---
 rtl/updown_step_scheduler.sv | 117 +++++++++++
 1 files changed

// File: rtl/updown_step_scheduler.sv
// updown_step_scheduler
//   Shared modulo up/down counter serviced by a two-requester round-robin
//   scheduler. A granted request steps the counter once per clock, up or
//   down with wrap-around, for the requested number of steps. Completion is
//   reported with a one-cycle done pulse tagged with the requester ID.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   req[1:0]    per-requester request, held until the matching ack
//   req_dir     per-requester direction (1 = up, 0 = down)
//   req_steps0  step count of requester 0
//   req_steps1  step count of requester 1
//   ack[1:0]    one-cycle one-hot acceptance pulse
//   busy        high while a request is being serviced (FSM not IDLE)
//   done        one-cycle completion pulse
//   done_id     requester that completed, valid with done
//   count       current counter value
module updown_step_scheduler #(
  parameter int WIDTH = 4,
  parameter int STEPW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       req_dir,
  input  logic [STEPW-1:0] req_steps0,
  input  logic [STEPW-1:0] req_steps1,
  output logic [1:0]       ack,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [1:0]       state;
  logic [STEPW-1:0] remaining;
  logic             owner;
  logic             last_grant;
  logic             dir;

  logic             winner;
  logic [STEPW-1:0] win_steps;

  // Round-robin: a lone requester wins outright; under contention the
  // requester that was not granted last time wins.
  always_comb begin
    winner = ~last_grant;
    if (req == 2'b01) winner = 1'b0;
    else if (req == 2'b10) winner = 1'b1;
    win_steps = winner ? req_steps1 : req_steps0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      remaining  <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      dir        <= 1'b0;
    end else begin
      ack  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner      <= winner;
            last_grant <= winner;
            dir        <= req_dir[winner];
            remaining  <= win_steps;
            ack        <= winner ? 2'b10 : 2'b01;
            busy       <= 1'b1;
            // A zero-step request skips RUN; its done pulse coincides with ack.
            if (win_steps != '0) begin
              state <= RUN;
            end else begin
              state   <= DONE;
              done    <= 1'b1;
              done_id <= winner;
            end
          end
        end
        RUN: begin
          if (dir) count <= (count == MAX) ? '0 : count + 1'b1;
          else     count <= (count == '0) ? MAX : count - 1'b1;
          remaining <= remaining - 1'b1;
          // done is registered, so it is raised on the edge of the last step.
          if (remaining == STEPW'(1)) begin
            state   <= DONE;
            done    <= 1'b1;
            done_id <= owner;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
